// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg : opcodes, ALU codes and control-FSM state encoding        |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package riscv_pkg;

   localparam logic [6:0] OPC_R    = 7'b0110011;
   localparam logic [6:0] OPC_IALU = 7'b0010011;
   localparam logic [6:0] OPC_LW   = 7'b0000011;
   localparam logic [6:0] OPC_SW   = 7'b0100011;
   localparam logic [6:0] OPC_BEQ  = 7'b1100011;

   // Shared with the ALU; values must stay in step with its operation decode.
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLT = 4'b0100;
   localparam logic [3:0] ALU_XOR = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_BAD  = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEMORY    = 3'd3,
      WRITEBACK = 3'd4
   } state_t;

   function automatic logic is_alu_type(input logic [6:0] opcode);
      return (opcode == OPC_R) || (opcode == OPC_IALU);
   endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_decoder : opcode/funct3/funct7[5] -> ALU code and legality flag  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module alu_decoder
   import riscv_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   output logic [3:0] alu_op_o,
   output logic       legal_o
);

   logic w_is_r;

   assign w_is_r = (opcode_i == OPC_R);

   always_comb begin
      alu_op_o = ALU_ADD;
      legal_o  = 1'b0;
      if (is_alu_type(opcode_i)) begin
         legal_o = (funct3_i != F3_BAD);
         case (funct3_i)
            // Immediate forms carry imm[10] in bit 30, so only R-type may select SUB.
            F3_ADD:  alu_op_o = (w_is_r && funct7b5_i) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_op_o = ALU_SLL;
            F3_SLT:  alu_op_o = ALU_SLT;
            F3_XOR:  alu_op_o = ALU_XOR;
            F3_SR:   alu_op_o = funct7b5_i ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_op_o = ALU_OR;
            F3_AND:  alu_op_o = ALU_AND;
            default: alu_op_o = ALU_ADD;
         endcase
      end else begin
         case (opcode_i)
            OPC_LW, OPC_SW: begin
               alu_op_o = ALU_ADD;
               legal_o  = (funct3_i == F3_WORD);
            end
            OPC_BEQ: begin
               alu_op_o = ALU_SUB;
               legal_o  = (funct3_i == F3_BEQ);
            end
            default: begin
               alu_op_o = ALU_ADD;
               legal_o  = 1'b0;
            end
         endcase
      end
   end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_control : fetch/decode/execute/memory/writeback sequencer |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module multicycle_control
   import riscv_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             zero,
   input  logic             mem_ready,
   output logic [3:0]       alu_op,
   output logic             alu_src,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   instret_q, instret_d;
   logic               w_retire;

   logic [6:0]         w_opcode;
   logic [3:0]         w_dec_alu_op;
   logic               w_dec_legal;
   logic               w_is_lw;
   logic               w_is_beq;
   logic               w_unused_instr;

   assign w_opcode       = instr[6:0];
   assign w_is_lw        = (w_opcode == OPC_LW);
   assign w_is_beq       = (w_opcode == OPC_BEQ);
   assign w_unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   alu_decoder u_alu_decoder (
      .opcode_i   (w_opcode),
      .funct3_i   (instr[14:12]),
      .funct7b5_i (instr[30]),
      .alu_op_o   (w_dec_alu_op),
      .legal_o    (w_dec_legal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   assign instret_d = w_retire ? instret_q + CNT_W'(1) : instret_q;
   assign instret   = instret_q;

   always_comb begin
      state_d    = state_q;
      w_retire   = 1'b0;
      alu_op     = ALU_ADD;
      alu_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;

      // Reset is asynchronous, so strobes must be silenced in the very cycle it rises.
      if (!rst) begin
         case (state_q)
            FETCH: begin
               mem_read = 1'b1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  state_d  = DECODE;
               end
            end

            DECODE: begin
               if (w_dec_legal) begin
                  state_d = EXECUTE;
               end else begin
                  illegal  = 1'b1;
                  pc_write = 1'b1;
                  state_d  = FETCH;
               end
            end

            EXECUTE: begin
               alu_op = w_dec_alu_op;
               if (w_is_beq) begin
                  pc_write = 1'b1;
                  pc_src   = zero;
                  w_retire = 1'b1;
                  state_d  = FETCH;
               end else if (is_alu_type(w_opcode)) begin
                  alu_src = (w_opcode == OPC_IALU);
                  state_d = WRITEBACK;
               end else begin
                  alu_src = 1'b1;
                  state_d = MEMORY;
               end
            end

            MEMORY: begin
               if (w_is_lw) begin
                  mem_read = 1'b1;
                  if (mem_ready) begin
                     state_d = WRITEBACK;
                  end
               end else begin
                  mem_write = 1'b1;
                  if (mem_ready) begin
                     pc_write = 1'b1;
                     w_retire = 1'b1;
                     state_d  = FETCH;
                  end
               end
            end

            WRITEBACK: begin
               reg_write  = 1'b1;
               mem_to_reg = w_is_lw;
               pc_write   = 1'b1;
               w_retire   = 1'b1;
               state_d    = FETCH;
            end

            default: begin
               state_d = FETCH;
            end
         endcase
      end
   end

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multicycle_control : directed self-checking bench for the FSM     |
// | Revision              : 1.0                                          |
// +----------------------------------------------------------------------+
module tb_multicycle_control;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic [3:0]  alu_op;
   logic        alu_src, ir_write, pc_write, pc_src, mem_read, mem_write;
   logic        mem_to_reg, reg_write, illegal;
   logic [31:0] instret;
   logic [12:0] strobes;

   int n_cmp = 0;
   int n_err = 0;

   // {alu_op, alu_src, ir_write, pc_write, pc_src, mem_read, mem_write, mem_to_reg, reg_write, illegal}
   localparam logic [12:0] E_IDLE   = 13'b0010_000000000;
   localparam logic [12:0] E_FWAIT  = 13'b0010_000010000;
   localparam logic [12:0] E_FRDY   = 13'b0010_010010000;
   localparam logic [12:0] E_WBR    = 13'b0010_001000010;
   localparam logic [12:0] E_WBL    = 13'b0010_001000110;
   localparam logic [12:0] E_ILL    = 13'b0010_001000001;
   localparam logic [12:0] E_MWR    = 13'b0010_000001000;
   localparam logic [12:0] E_MWRRDY = 13'b0010_001001000;
   localparam logic [12:0] E_EXADDI = 13'b0010_100000000;
   localparam logic [12:0] E_EXSUB  = 13'b0110_000000000;
   localparam logic [12:0] E_EXSRAI = 13'b1010_100000000;
   localparam logic [12:0] E_EXXOR  = 13'b0101_000000000;
   localparam logic [12:0] E_BEQT   = 13'b0110_001100000;
   localparam logic [12:0] E_BEQN   = 13'b0110_001000000;

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_SUB   = 32'h402081B3;
   localparam logic [31:0] I_SRAI  = 32'h4030D293;
   localparam logic [31:0] I_XOR   = 32'h0020C1B3;
   localparam logic [31:0] I_ADDI  = 32'h40000093;
   localparam logic [31:0] I_LW    = 32'h0000A283;
   localparam logic [31:0] I_SW    = 32'h0050A223;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_ONES  = 32'hFFFFFFFF;
   localparam logic [31:0] I_F3BAD = 32'h0020B1B3;
   localparam logic [31:0] I_LB    = 32'h00008283;

   assign strobes = {alu_op, alu_src, ir_write, pc_write, pc_src, mem_read,
                     mem_write, mem_to_reg, reg_write, illegal};

   multicycle_control #(.CNT_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .instr      (instr),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .alu_op     (alu_op),
      .alu_src    (alu_src),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .illegal    (illegal),
      .instret    (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs just after the edge, check the combinational strobes, then advance.
   task automatic cyc(input string tag, input logic [31:0] ins, input logic rdy,
                      input logic z, input logic [12:0] exp);
      instr     = ins;
      mem_ready = rdy;
      zero      = z;
      #1;
      chk(tag, {19'd0, strobes}, {19'd0, exp});
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      instr     = I_ADD;
      zero      = 1'b0;
      mem_ready = 1'b1;
      #1;
      chk("reset_strobes", {19'd0, strobes}, {19'd0, E_IDLE});
      chk("reset_instret", instret, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      cyc("add_fetch",  I_ADD, 1'b1, 1'b0, E_FRDY);
      cyc("add_decode", I_ADD, 1'b1, 1'b0, E_IDLE);
      chk("add_instret_mid", instret, 32'd0);
      cyc("add_exec",   I_ADD, 1'b1, 1'b0, E_IDLE);
      cyc("add_wb",     I_ADD, 1'b1, 1'b0, E_WBR);
      chk("add_instret", instret, 32'd1);

      cyc("sub_fetch",  I_SUB, 1'b1, 1'b0, E_FRDY);
      cyc("sub_decode", I_SUB, 1'b1, 1'b0, E_IDLE);
      cyc("sub_exec",   I_SUB, 1'b1, 1'b0, E_EXSUB);
      cyc("sub_wb",     I_SUB, 1'b1, 1'b0, E_WBR);

      cyc("srai_fetch",  I_SRAI, 1'b1, 1'b0, E_FRDY);
      cyc("srai_decode", I_SRAI, 1'b1, 1'b0, E_IDLE);
      cyc("srai_exec",   I_SRAI, 1'b1, 1'b0, E_EXSRAI);
      cyc("srai_wb",     I_SRAI, 1'b1, 1'b0, E_WBR);

      cyc("xor_fetch",  I_XOR, 1'b1, 1'b0, E_FRDY);
      cyc("xor_decode", I_XOR, 1'b1, 1'b0, E_IDLE);
      cyc("xor_exec",   I_XOR, 1'b1, 1'b0, E_EXXOR);
      cyc("xor_wb",     I_XOR, 1'b1, 1'b0, E_WBR);

      cyc("addi_fetch",  I_ADDI, 1'b1, 1'b0, E_FRDY);
      cyc("addi_decode", I_ADDI, 1'b1, 1'b0, E_IDLE);
      cyc("addi_exec",   I_ADDI, 1'b1, 1'b0, E_EXADDI);
      cyc("addi_wb",     I_ADDI, 1'b1, 1'b0, E_WBR);
      chk("alu_instret", instret, 32'd5);

      cyc("lw_fetch",  I_LW, 1'b1, 1'b0, E_FRDY);
      cyc("lw_decode", I_LW, 1'b1, 1'b0, E_IDLE);
      cyc("lw_exec",   I_LW, 1'b1, 1'b0, E_EXADDI);
      for (int i = 0; i < 3; i++) begin
         cyc("lw_mem_wait", I_LW, 1'b0, 1'b0, E_FWAIT);
      end
      cyc("lw_mem_ready", I_LW, 1'b1, 1'b0, E_FWAIT);
      chk("lw_instret_pre_wb", instret, 32'd5);
      cyc("lw_wb",        I_LW, 1'b1, 1'b0, E_WBL);
      chk("lw_instret", instret, 32'd6);

      cyc("sw_fetch_wait0", I_SW, 1'b0, 1'b0, E_FWAIT);
      cyc("sw_fetch_wait1", I_SW, 1'b0, 1'b0, E_FWAIT);
      cyc("sw_fetch",       I_SW, 1'b1, 1'b0, E_FRDY);
      cyc("sw_decode",      I_SW, 1'b1, 1'b0, E_IDLE);
      cyc("sw_exec",        I_SW, 1'b1, 1'b0, E_EXADDI);
      cyc("sw_mem_wait",    I_SW, 1'b0, 1'b0, E_MWR);
      cyc("sw_mem_ready",   I_SW, 1'b1, 1'b0, E_MWRRDY);
      chk("sw_instret", instret, 32'd7);

      cyc("beqt_fetch",  I_BEQ, 1'b1, 1'b1, E_FRDY);
      cyc("beqt_decode", I_BEQ, 1'b1, 1'b1, E_IDLE);
      cyc("beqt_exec",   I_BEQ, 1'b1, 1'b1, E_BEQT);
      chk("beqt_instret", instret, 32'd8);

      cyc("beqn_fetch",  I_BEQ, 1'b1, 1'b0, E_FRDY);
      cyc("beqn_decode", I_BEQ, 1'b1, 1'b0, E_IDLE);
      cyc("beqn_exec",   I_BEQ, 1'b1, 1'b0, E_BEQN);
      chk("beqn_instret", instret, 32'd9);

      cyc("ones_fetch",  I_ONES, 1'b1, 1'b0, E_FRDY);
      cyc("ones_decode", I_ONES, 1'b1, 1'b0, E_ILL);
      chk("ones_instret", instret, 32'd9);

      cyc("f3bad_fetch",  I_F3BAD, 1'b1, 1'b0, E_FRDY);
      cyc("f3bad_decode", I_F3BAD, 1'b1, 1'b0, E_ILL);
      cyc("lb_fetch",     I_LB,    1'b1, 1'b0, E_FRDY);
      cyc("lb_decode",    I_LB,    1'b1, 1'b0, E_ILL);
      chk("illegal_instret", instret, 32'd9);

      cyc("lw2_fetch",    I_LW, 1'b1, 1'b0, E_FRDY);
      cyc("lw2_decode",   I_LW, 1'b1, 1'b0, E_IDLE);
      cyc("lw2_exec",     I_LW, 1'b1, 1'b0, E_EXADDI);
      cyc("lw2_mem_wait", I_LW, 1'b0, 1'b0, E_FWAIT);
      mem_ready = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_strobes", {19'd0, strobes}, {19'd0, E_IDLE});
      chk("midrst_instret", instret, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc("postrst_fetch_wait", I_LW, 1'b0, 1'b0, E_FWAIT);
      cyc("postrst_fetch",      I_LW, 1'b1, 1'b0, E_FRDY);
      chk("postrst_instret", instret, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_multicycle_control
`default_nettype wire
